add_sub_64bit: RTL and testbench

- 64-bit two's-complement adder/subtractor with signed-overflow detection.
- Serves the pipelined Y86 processor's execute-stage ALU (add/sub paths).
- Inputs are sampled on every clock edge; `sum` and `OF` are registered outputs.
- The datapath is a ripple/complement structure: b is XORed with m, and m is the carry-in.

---
 rtl/add_sub_64bit_if.sv | 27 ++
 rtl/add_sub_64bit.sv | 36 +++
 tb/tb_add_sub_64bit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/add_sub_64bit_if.sv
// Operand/result bundle for the execute-stage add/sub unit.
// No valid/ready: a, b, m are sampled on every rising clk edge; sum/OF update one edge later and hold between edges.
interface add_sub_64bit_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] sum;
    logic             OF;

    modport master (
        output a,
        output b,
        output m,
        input  sum,
        input  OF
    );

    modport slave (
        input  a,
        input  b,
        input  m,
        output sum,
        output OF
    );
endinterface

// File: rtl/add_sub_64bit.sv
// 64-bit two's-complement adder/subtractor with registered result and signed-overflow flag.
// Subtract reuses the adder: b is complemented by m and m is the carry-in.
module add_sub_64bit #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_64bit_if.slave bus
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] result;
    logic             of;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             of_d, of_q;

    always_comb begin
        bx     = bus.b ^ {WIDTH{bus.m}};
        result = bus.a + bx + {{(WIDTH-1){1'b0}}, bus.m};
        // Same-sign operands into the adder producing a different-sign result.
        of     = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (result[WIDTH-1] != bus.a[WIDTH-1]);
        sum_d  = result;
        of_d   = of;
        if (!rst_n) begin
            sum_d = '0;
            of_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
        of_q  <= of_d;
    end

    assign bus.sum = sum_q;
    assign bus.OF  = of_q;
endmodule

// File: tb/tb_add_sub_64bit.sv
// Bench for add_sub_64bit: directed boundary vectors plus randomized operations against a wide-integer model.
module tb_add_sub_64bit;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_sub_64bit_if #(.WIDTH(W)) bus_if ();

    add_sub_64bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    // Reference: exact signed arithmetic in 66 bits, overflow = result outside the 64-bit signed range.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        logic signed [W+1:0] sa, sb, full, max_pos, min_neg;
        logic                of;
        sa      = $signed({{2{a[W-1]}}, a});
        sb      = $signed({{2{b[W-1]}}, b});
        full    = m ? (sa - sb) : (sa + sb);
        max_pos = (66'sd1 <<< (W - 1)) - 66'sd1;
        min_neg = -(66'sd1 <<< (W - 1));
        of      = (full > max_pos) || (full < min_neg);
        return {of, full[W-1:0]};
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic rn);
        @(negedge clk);
        bus_if.a = a;
        bus_if.b = b;
        bus_if.m = m;
        rst_n    = rn;
    endtask

    task automatic test_reset;
        logic [W:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            exp_q.push_back('0);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if ({bus_if.OF, bus_if.sum} !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got sum=%h OF=%b, expected sum=%h OF=%b", i, bus_if.sum, bus_if.OF, exp[W-1:0], exp[W]);
            end
        end
        drive(64'd2811, 64'd1012, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 64'd1799});
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        checks++;
        if ({bus_if.OF, bus_if.sum} !== exp) begin
            errors++;
            $display("FAIL first_sub: got sum=%h OF=%b, expected sum=%h OF=%b", bus_if.sum, bus_if.OF, exp[W-1:0], exp[W]);
        end
    endtask

    // Directed vectors {a, b, m, expected OF, expected sum} applied back to back.
    task automatic test_directed;
        logic [W-1:0] va[14], vb[14], vs[14];
        logic         vm[14], vo[14];
        logic [W:0]   exp;
        va = '{-64'sd1243, -64'sd7478, -64'sd1092835, 64'sd7890678653,
               64'h8000000000000001, -64'sd9223372036854770000, 64'sd9223372036854775800,
               64'h7FFFFFFFFFFFFFFF, -64'sd1, 64'h8000000000000000, 64'sd100,
               64'd0, 64'h0123456789ABCDEF, 64'd0};
        vb = '{64'sd1234, -64'sd46474, 64'sd1020, 64'sd4238598110567,
               64'sd2, 64'sd6000, -64'sd10,
               64'sd1, 64'sd1, 64'h8000000000000000, -64'sd300,
               64'd0, 64'd0, 64'h8000000000000000};
        vm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vs = '{-64'sd2477, 64'sd38996, -64'sd1093855, -64'sd4230707431914,
               64'h7FFFFFFFFFFFFFFF, 64'd9223372036854775616, 64'h8000000000000002,
               64'h8000000000000000, 64'd0, 64'd0, -64'sd200,
               64'd0, 64'h0123456789ABCDEF, 64'h8000000000000000};
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            drive(va[i], vb[i], vm[i], 1'b1);
            exp_q.push_back({vo[i], vs[i]});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if ({bus_if.OF, bus_if.sum} !== exp) begin
                errors++;
                $display("FAIL directed[%0d]: got sum=%h OF=%b, expected sum=%h OF=%b", i, bus_if.sum, bus_if.OF, exp[W-1:0], exp[W]);
            end
        end
    endtask

    task automatic test_toggle_mid_reset;
        logic [W:0] exp;
        logic       m, rn;
        for (int i = 0; i < 10; i++) begin
            m  = 1'(i % 2);
            rn = (i != 5);
            drive(64'd5, 64'd3, m, rn);
            exp_q.push_back(rn ? {1'b0, (m ? 64'd2 : 64'd8)} : '0);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if ({bus_if.OF, bus_if.sum} !== exp) begin
                errors++;
                $display("FAIL toggle[%0d]: got sum=%h OF=%b, expected sum=%h OF=%b", i, bus_if.sum, bus_if.OF, exp[W-1:0], exp[W]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         m;
        logic [W:0]   exp;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            // Bias some operands toward the signed extremes to exercise overflow.
            case ($urandom_range(0, 5))
                0: a = {1'b0, {(W-1){1'b1}}} - 64'($urandom_range(0, 3));
                1: a = {1'b1, {(W-1){1'b0}}} + 64'($urandom_range(0, 3));
                2: b = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            m = 1'($urandom_range(0, 1));
            drive(a, b, m, 1'b1);
            exp_q.push_back(model(a, b, m));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if ({bus_if.OF, bus_if.sum} !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h m=%b: got sum=%h OF=%b, expected sum=%h OF=%b",
                         i, a, b, m, bus_if.sum, bus_if.OF, exp[W-1:0], exp[W]);
            end
        end
    endtask

    initial begin
        bus_if.a = '0;
        bus_if.b = '0;
        bus_if.m = 1'b0;
        test_reset();
        test_directed();
        test_toggle_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
